// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter fed by the dds block.
// Paces the DDS with one query per frame, captures the returned sample after a
// fixed latency, and sends it as a mono word on both the left and right slots.
// BCLK and LRCLK are generated here, so the DAC runs as a slave.
module i2s_tx #(
  parameter int DATA_WDTH  = 24,
  parameter int SLOT_WDTH  = 32,
  parameter int BCLK_DIV   = 2,
  parameter int SAMPLE_LAT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mute,
  input  logic signed [DATA_WDTH-1:0] sine,
  output logic                        query_sine,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WDTH);
  localparam int LAT_W = (SAMPLE_LAT > 0) ? $clog2(SAMPLE_LAT + 1) : 1;

  // Latency tracker: idle until a query goes out, then waits for the DDS result.
  typedef enum logic {
    LAT_IDLE = 1'b0,
    LAT_WAIT = 1'b1
  } lat_state_t;

  logic [DIV_W-1:0]            r_div_cnt;
  logic [BIT_W-1:0]            r_bit_cnt;
  logic [LAT_W-1:0]            r_lat_cnt;
  lat_state_t                  r_lat_state;
  lat_state_t                  w_lat_state_nxt;
  logic signed [DATA_WDTH-1:0] r_pending;
  logic signed [DATA_WDTH-1:0] r_active;
  logic                        r_bclk;
  logic                        r_lrclk;
  logic                        r_sdata;
  logic                        r_query;

  logic                        w_div_wrap;
  logic                        w_fall;
  logic [BIT_W-1:0]            w_bit_nxt;
  logic [BIT_W-1:0]            w_pos;
  logic                        w_lr_nxt;
  logic                        w_sdata_nxt;
  logic                        w_frame_start;
  logic                        w_req;
  logic                        w_capture;

  // Next bit position and serial bit that take effect on the coming BCLK fall.
  always_comb begin
    w_div_wrap    = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    w_fall        = w_div_wrap & r_bclk;
    w_bit_nxt     = (r_bit_cnt == BIT_W'(2 * SLOT_WDTH - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
    w_lr_nxt      = (w_bit_nxt >= BIT_W'(SLOT_WDTH));
    w_pos         = w_lr_nxt ? (w_bit_nxt - BIT_W'(SLOT_WDTH)) : w_bit_nxt;
    w_frame_start = w_fall & (w_bit_nxt == '0);
    w_req         = w_fall & (w_bit_nxt == BIT_W'(SLOT_WDTH));
    w_capture     = (r_lat_state == LAT_WAIT) && (r_lat_cnt == LAT_W'(SAMPLE_LAT));
    // Slot position 0 is the I2S one-bit delay; positions past the word are padding.
    w_sdata_nxt   = 1'b0;
    for (int k = 1; k <= DATA_WDTH; k++) begin
      if (int'(w_pos) == k) w_sdata_nxt = r_active[DATA_WDTH-k];
    end
  end

  // Clock divider: BCLK toggles every BCLK_DIV system clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Bit counter, word select and serial data all change with the BCLK fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_nxt;
      r_lrclk   <= w_lr_nxt;
      r_sdata   <= w_sdata_nxt;
    end
  end

  // Frame boundary: latch the word sent on both slots of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
    end else if (w_frame_start) begin
      r_active <= mute ? '0 : r_pending;
    end
  end

  // One-cycle DDS request at the start of the right slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_query <= 1'b0;
    end else begin
      r_query <= w_req;
    end
  end

  // Latency tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_state <= LAT_IDLE;
    end else begin
      r_lat_state <= w_lat_state_nxt;
    end
  end

  // Latency tracker next state: arm on a request, disarm on the capture edge.
  always_comb begin
    w_lat_state_nxt = r_lat_state;
    case (r_lat_state)
      LAT_IDLE: if (w_req) w_lat_state_nxt = LAT_WAIT;
      LAT_WAIT: if (w_capture) w_lat_state_nxt = LAT_IDLE;
      default:  w_lat_state_nxt = LAT_IDLE;
    endcase
  end

  // Edge count since the request; equals SAMPLE_LAT on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
    end else if (w_req) begin
      r_lat_cnt <= LAT_W'(1);
    end else if (w_capture) begin
      r_lat_cnt <= '0;
    end else if (r_lat_state == LAT_WAIT) begin
      r_lat_cnt <= r_lat_cnt + LAT_W'(1);
    end
  end

  // Capture the DDS sample exactly SAMPLE_LAT edges after the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (w_capture) begin
      r_pending <= sine;
    end
  end

  assign query_sine = r_query;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;

endmodule
